rr_arb_mux: RTL and testbench
=============================

# rr_arb_mux

Parametrised N-input, WIDTH-bit multiplexer with valid/ready handshakes, round-robin or externally-forced selection, and a registered output stage. It generalises the datapath source-select muxes to multi-requester paths (e.g. writeback/result buses shared by several producers), adds fair arbitration and back-pressure, and decouples timing with a one-entry output register.

## Interface
- WIDTH, 32, data width of every channel
- NUM_IN, 3, number of input channels (≥2); SEL_W = $clog2(NUM_IN) is a localparam
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = round-robin arbitration, 1 = forced selection via sel
- sel  in  SEL_W  forced channel index (used when mode=1)
- in_valid  in  NUM_IN  per-channel beat valid
- in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  NUM_IN  per-channel accept; at most one bit high per cycle
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered beat data
- out_sel  out  SEL_W  index of the channel that produced out_data
- out_ready  in  1  downstream accepts out_data

## Operation
- Output register "can load" when out_valid=0 or out_ready=1.
- Grant (combinational): mode=0 → first i with in_valid[i]=1 scanning ptr, ptr+1, … wrapping mod NUM_IN; mode=1 → channel sel if sel<NUM_IN and in_valid[sel]=1, else no grant (out-of-range sel never grants, never wraps).
- in_ready[g] = grant present for g AND can load. Beat transfers when in_valid[g] & in_ready[g].
- On transfer: out_data←in_data[g], out_sel←g, out_valid←1.
- On out_valid & out_ready with no transfer: out_valid←0; out_data/out_sel hold last value.
- Round-robin pointer ptr (SEL_W bits): on any transfer from g, ptr←(g+1) mod NUM_IN (wraps from NUM_IN-1 to 0, never takes values ≥NUM_IN). Updated in both modes; no transfer → ptr holds.
- in_ready may depend combinationally on out_ready; in_valid→in_ready has no loop back to in_valid.
- Reset (async, any time, including mid-packet): out_valid=0, out_data=0, out_sel=0, ptr=0, lock cleared; in_ready=0 while rst=1. Pending beats are not lost on the input side because none were accepted.

## Timing
- Latency: input transfer at edge n → out_valid=1 with that data after edge n.
- Throughput: one beat per cycle while out_ready=1 held high.
- Back-pressure: out_valid=1 & out_ready=0 → all in_ready=0; out_data, out_sel stable until accepted.
- Simultaneous accept of old beat and load of new in same cycle: out_valid stays 1, data replaced.
- mode/sel are sampled combinationally each cycle; a change takes effect on the next grant decision.

## Configuration
- Macro RR_MUX_LAST_LOCK_EN.
- Defined: adds ports in_last (in, NUM_IN) and out_last (out, 1, reset 0, registered with data). After a transfer with in_last=0, grant locks to that channel; grant ignores mode, sel and other requests until a beat with in_last=1 is transferred from the locked channel, then unlocks and ptr advances. Reset clears lock.
- Undefined: no last ports, no lock; arbitration per beat.

## Test plan
- Reset: assert rst mid-transfer with out_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately (async); after release first grant goes to channel 0.
- Round-robin fairness: NUM_IN=3, all in_valid=1 continuously, out_ready=1 → out_sel sequence 0,1,2,0,1,2, one beat per cycle, out_data matches per-channel counters.
- Back-pressure: hold out_ready=0 for 4 cycles with out_valid=1 → out_data/out_sel stable, in_ready=0; release → beat consumed and next grant loaded same cycle.
- Forced mode: mode=1, sel=2, all valid → only channel 2 transfers; sel=3 (out of range) → no in_ready, out_valid drops after current beat accepted.
- Sparse requests / wrap: only channel 2 valid, then only channel 0 → ptr wraps 2→0, channel 0 granted next cycle; idle cycles produce out_valid=0.
- With RR_MUX_LAST_LOCK_EN: channel 1 sends 3-beat packet (last on beat 3) while channels 0 and 2 valid → out_sel = 1,1,1 then 2, then 0; out_last=1 only with the third beat.

Source files
------------

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: N-channel valid/ready bundle for rr_arb_mux.
// Macro RR_MUX_LAST_LOCK_EN adds in_last/out_last packet framing.
interface rr_arb_mux_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;
`ifdef RR_MUX_LAST_LOCK_EN
  logic [NUM_IN-1:0]       in_last;
  logic                    out_last;
`endif

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
`ifdef RR_MUX_LAST_LOCK_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
`ifdef RR_MUX_LAST_LOCK_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-in round-robin/forced mux, registered output stage.
// Ports: clk, rst (async high), bus (slave); macro RR_MUX_LAST_LOCK_EN.
module rr_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3
) (
  input  logic        clk,
  input  logic        rst,
  rr_arb_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             can_load;
  logic             xfer;
`ifdef RR_MUX_LAST_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
  logic             out_last_q, out_last_d;
  logic             gnt_last;
`endif

  assign can_load = ~out_valid_q | bus.out_ready;
  assign xfer     = gnt_vld & can_load & ~rst;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (bus.mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Pass 1: lowest requester below ptr (wrapped part).
      // Pass 2: lowest at/above ptr overrides it.
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (bus.in_valid[i] && SEL_W'(i) < ptr_q) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (bus.in_valid[i] && SEL_W'(i) >= ptr_q) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end
`ifdef RR_MUX_LAST_LOCK_EN
    // Mid-packet: only the locked channel may transfer.
    if (lock_q) begin
      gnt_vld = 1'b0;
      gnt_idx = lock_idx_q;
      for (int i = 0; i < NUM_IN; i++) begin
        if (lock_idx_q == SEL_W'(i) && bus.in_valid[i]) begin
          gnt_vld = 1'b1;
        end
      end
    end
`endif
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      bus.in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_sel_d   = gnt_idx;
      ptr_d       = (gnt_idx == SEL_W'(NUM_IN - 1))
                  ? '0 : gnt_idx + SEL_W'(1);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef RR_MUX_LAST_LOCK_EN
  always_comb begin
    gnt_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_last = bus.in_last[i];
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    out_last_d = out_last_q;
    if (xfer) begin
      lock_d     = ~gnt_last;
      lock_idx_d = gnt_idx;
      out_last_d = gnt_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      out_last_q <= out_last_d;
    end
  end

  assign bus.out_last = out_last_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed stimulus, scoreboard queue + output monitor.
// Channel i beat n carries 0xD000_0000 | i<<16 | n.
`timescale 1ns/1ps
module tb_rr_arb_mux;
  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt[N] = '{default: 0};
  logic [N-1:0]    fire = '0;
  logic [SW+W-1:0] sbq[$];

  rr_arb_mux_if #(.WIDTH(W), .NUM_IN(N)) bus();

  rr_arb_mux #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dat(int ch, int n);
    return 32'hD000_0000 | (32'(ch) << 16) | 32'(n);
  endfunction

  always_comb begin
    bus.in_data = '0;
    for (int i = 0; i < N; i++) begin
      bus.in_data[i*W +: W] = dat(i, cnt[i]);
    end
  end

  // Source model: advance a channel's counter when its beat is taken.
  always @(negedge clk) fire = bus.in_valid & bus.in_ready;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (fire[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  // Monitor: a beat is consumed at the edge following this negedge.
  always @(negedge clk) begin
    logic [SW+W-1:0] got, exp;
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_vec++;
      got = {bus.out_sel, bus.out_data};
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: got sel=%0d data=%h, nothing expected",
                 bus.out_sel, bus.out_data);
      end else begin
        exp = sbq.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL sb_beat: got sel=%0d data=%h, want sel=%0d data=%h",
                   got[SW+W-1:W], got[W-1:0], exp[SW+W-1:W], exp[W-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic push(int ch, int n);
    sbq.push_back({SW'(ch), dat(ch, n)});
  endtask

  initial begin
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_valid  = 3'b111;
    bus.out_ready = 1'b1;
`ifdef RR_MUX_LAST_LOCK_EN
    bus.in_last   = 3'b111;
`endif
    #1;
    chk("rst_valid", 64'(bus.out_valid), 0);
    chk("rst_data", 64'(bus.out_data), 0);
    chk("rst_sel", 64'(bus.out_sel), 0);
    chk("rst_ready", 64'(bus.in_ready), 0);
    tick();
    tick();
    bus.in_valid = '0;
    rst = 1'b0;
    tick();

    // Round-robin, all requesting, sink always ready.
    push(0, 0); push(1, 0); push(2, 0);
    push(0, 1); push(1, 1); push(2, 1);
    bus.in_valid = 3'b111;
    tick();
    chk("latency_valid", 64'(bus.out_valid), 1);
    chk("latency_sel", 64'(bus.out_sel), 0);
    repeat (5) tick();
    bus.in_valid = '0;
    tick();
    chk("rr_drain", 64'(bus.out_valid), 0);

    // Back-pressure for 4 cycles, then release.
    bus.out_ready = 1'b0;
    bus.in_valid  = 3'b111;
    push(0, 2);
    tick();
    repeat (4) begin
      tick();
      chk("bp_ready", 64'(bus.in_ready), 0);
      chk("bp_sel", 64'(bus.out_sel), 0);
      chk("bp_data", 64'(bus.out_data), 64'(dat(0, 2)));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'(3'b010));
    push(1, 2);
    tick();
    chk("bp_reload_sel", 64'(bus.out_sel), 1);
    bus.in_valid = '0;
    tick();
    chk("bp_drain", 64'(bus.out_valid), 0);

    // Forced selection, then out-of-range sel.
    bus.mode     = 1'b1;
    bus.sel      = 2'd2;
    bus.in_valid = 3'b111;
    push(2, 2); push(2, 3); push(2, 4);
    repeat (3) tick();
    bus.sel = 2'd3;
    #1;
    chk("oob_ready", 64'(bus.in_ready), 0);
    tick();
    chk("oob_drop", 64'(bus.out_valid), 0);
    tick();
    chk("oob_idle", 64'(bus.out_valid), 0);
    bus.mode     = 1'b0;
    bus.in_valid = '0;

    // Sparse requests: pointer wrap 2->0, then skip to 2 from ptr=1.
    bus.in_valid = 3'b100;
    push(2, 5);
    tick();
    bus.in_valid = 3'b001;
    push(0, 3);
    tick();
    chk("wrap_sel", 64'(bus.out_sel), 0);
    bus.in_valid = 3'b101;
    push(2, 6); push(0, 4);
    tick();
    chk("skip_sel", 64'(bus.out_sel), 2);
    tick();
    chk("skip_next", 64'(bus.out_sel), 0);
    bus.in_valid = '0;
    tick();
    chk("sparse_idle", 64'(bus.out_valid), 0);

    // Async reset with a beat held in the output register.
    bus.out_ready = 1'b0;
    bus.in_valid  = 3'b111;
    tick();
    chk("pre_rst_valid", 64'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 0);
    chk("arst_data", 64'(bus.out_data), 0);
    chk("arst_sel", 64'(bus.out_sel), 0);
    chk("arst_ready", 64'(bus.in_ready), 0);
    tick();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(bus.in_ready), 64'(3'b001));
    push(0, 5);
    tick();
    chk("post_rst_sel", 64'(bus.out_sel), 0);

`ifdef RR_MUX_LAST_LOCK_EN
    // Channel 1 three-beat packet while 0 and 2 keep requesting.
    bus.in_last = 3'b101;
    push(1, 4); push(1, 5); push(1, 6); push(2, 7); push(0, 6);
    tick();
    chk("lock_last1", 64'(bus.out_last), 0);
    chk("lock_ready", 64'(bus.in_ready), 64'(3'b010));
    tick();
    chk("lock_last2", 64'(bus.out_last), 0);
    bus.in_last = 3'b111;
    tick();
    chk("lock_last3", 64'(bus.out_last), 1);
    chk("lock_sel3", 64'(bus.out_sel), 1);
    tick();
    chk("unlock_sel", 64'(bus.out_sel), 2);
    tick();
`endif
    bus.in_valid = '0;
    repeat (2) tick();
    chk("sb_empty", 64'(sbq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
